// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Two-source round-robin arbiter with burst hold. It sits in front of a 2:1
// mux, drives the mux select and captures the mux output into a registered
// valid/ready output stage. A source keeps the grant for up to BURST
// transfers while the other source is waiting. A source that is alone keeps
// streaming without limit.

module mux_sel_arbiter #(
  parameter int WIDTH = 9,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             sel,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  // Counter value at which the active source must give way to a waiting peer.
  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             lastGrantB_q, lastGrantB_d;
  logic [3:0]       burstCnt_q, burstCnt_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;

  logic space;
  logic xferA, xferB;
  logic grantA, grantB;

  // The output register can take a word when it is empty or being drained.
  // Ready depends only on state and on the output stage, never on the
  // incoming valids, so the two sources cannot form a combinational loop
  // through the arbiter.
  always_comb begin
    space   = !outValid_q || out_ready;
    a_ready = (state_q == GRANT_A) && space;
    b_ready = (state_q == GRANT_B) && space;
    xferA   = a_valid && a_ready;
    xferB   = b_valid && b_ready;
  end

  // Next-state logic for the grant FSM. grantA and grantB request entry into a
  // grant state. Every entry sets sel, records the winner for round-robin and
  // clears the burst counter. Because sel is registered, mux_out stays stable
  // for the whole grant.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    lastGrantB_d = lastGrantB_q;
    burstCnt_d   = burstCnt_q;
    grantA       = 1'b0;
    grantB       = 1'b0;

    case (state_q)
      IDLE: begin
        grantA = a_valid && (!b_valid || lastGrantB_q);
        grantB = b_valid && (!a_valid || !lastGrantB_q);
      end
      GRANT_A: begin
        if ((xferA && (burstCnt_q == LAST_BEAT) && b_valid) || (!a_valid && b_valid)) begin
          grantB = 1'b1;
        end else if (!a_valid) begin
          state_d    = IDLE;
          burstCnt_d = 4'd0;
        end else if (xferA && (burstCnt_q != LAST_BEAT)) begin
          burstCnt_d = burstCnt_q + 4'd1;
        end
      end
      GRANT_B: begin
        if ((xferB && (burstCnt_q == LAST_BEAT) && a_valid) || (!b_valid && a_valid)) begin
          grantA = 1'b1;
        end else if (!b_valid) begin
          state_d    = IDLE;
          burstCnt_d = 4'd0;
        end else if (xferB && (burstCnt_q != LAST_BEAT)) begin
          burstCnt_d = burstCnt_q + 4'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        burstCnt_d = 4'd0;
      end
    endcase

    if (grantA) begin
      state_d      = GRANT_A;
      sel_d        = 1'b0;
      lastGrantB_d = 1'b0;
      burstCnt_d   = 4'd0;
    end else if (grantB) begin
      state_d      = GRANT_B;
      sel_d        = 1'b1;
      lastGrantB_d = 1'b1;
      burstCnt_d   = 4'd0;
    end
  end

  // The output stage loads the mux word on any accepted transfer. Otherwise it
  // empties once the consumer takes the word. The data is left untouched
  // until a new word replaces it.
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    if (xferA || xferB) begin
      outValid_d = 1'b1;
      outData_d  = mux_out;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State and output registers. Reset clears any in-flight word at once.
  // lastGrantB resets to 1 so that A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      lastGrantB_q <= 1'b1;
      burstCnt_q   <= 4'd0;
      outValid_q   <= 1'b0;
      outData_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      lastGrantB_q <= lastGrantB_d;
      burstCnt_q   <= burstCnt_d;
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter
// Drives two sources and a consumer around mux_sel_arbiter. The bench models
// the downstream 2:1 mux from the DUT's sel output. Each cycle it compares
// every DUT output against a behavioural model: who owns the grant, how many
// words that owner has moved, and what sits in the output register.

module tb_mux_sel_arbiter;

  localparam int WIDTH = 9;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             aValid, bValid, outReady;
  logic             aReady, bReady, selW, outValidW, busyW;
  logic [WIDTH-1:0] aData, bData, muxOut, outDataW;

  int total = 0;
  int bad   = 0;

  // Model state: owner 0 = nobody, 1 = A, 2 = B; run = words moved this grant.
  int               mOwner, mLast, mRun;
  bit               mSel, mOutValid;
  logic [WIDTH-1:0] mOutData;

  mux_sel_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (aValid),
    .a_ready  (aReady),
    .b_valid  (bValid),
    .b_ready  (bReady),
    .sel      (selW),
    .mux_out  (muxOut),
    .out_data (outDataW),
    .out_valid(outValidW),
    .out_ready(outReady),
    .busy     (busyW)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // The external 2:1 mux that the arbiter steers.
  assign muxOut = selW ? bData : aData;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mOwner    = 0;
    mLast     = 2;
    mRun      = 0;
    mSel      = 1'b0;
    mOutValid = 1'b0;
    mOutData  = '0;
  endtask

  task automatic modelEnter(input int who);
    mOwner = who;
    mLast  = who;
    mSel   = (who == 2);
    mRun   = 0;
  endtask

  // Run one clock: drive the inputs, check the outputs against the model,
  // advance the model, then replace any source word that was accepted.
  task automatic applyStimulus(input bit av, input bit bv, input bit orr);
    bit space, ar, br, xa, xb, mine, other;
    int next;
    @(negedge clk);
    aValid   = av;
    bValid   = bv;
    outReady = orr;
    #1;
    space = !mOutValid || orr;
    ar    = (mOwner == 1) && space;
    br    = (mOwner == 2) && space;
    checkOutput("a_ready",   9'(aReady),    9'(ar));
    checkOutput("b_ready",   9'(bReady),    9'(br));
    checkOutput("sel",       9'(selW),      9'(mSel));
    checkOutput("out_valid", 9'(outValidW), 9'(mOutValid));
    checkOutput("out_data",  outDataW,      mOutData);
    checkOutput("busy",      9'(busyW),     9'(mOwner != 0));
    checkOutput("excl",      9'(aReady & bReady), 9'd0);

    xa = av && ar;
    xb = bv && br;
    if (xa || xb) begin
      mOutData  = xa ? aData : bData;
      mOutValid = 1'b1;
    end else if (orr) begin
      mOutValid = 1'b0;
    end

    if (mOwner == 0) begin
      if (av && bv)  next = (mLast == 2) ? 1 : 2;
      else if (av)   next = 1;
      else if (bv)   next = 2;
      else           next = 0;
      if (next != 0) modelEnter(next);
    end else begin
      mine  = (mOwner == 1) ? av : bv;
      other = (mOwner == 1) ? bv : av;
      if (xa || xb) mRun++;
      if (((xa || xb) && mRun >= BURST && other) || (!mine && other)) begin
        modelEnter(3 - mOwner);
      end else if (!mine) begin
        mOwner = 0;
        mRun   = 0;
      end
    end

    @(posedge clk);
    #1;
    if (xa) aData = 9'($urandom);
    if (xb) bData = 9'($urandom);
  endtask

  initial begin
    rst_n    = 1'b0;
    aValid   = 1'b0;
    bValid   = 1'b0;
    outReady = 1'b0;
    aData    = 9'h1A5;
    bData    = 9'h0FF;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 9'(outValidW), 9'd0);
    checkOutput("rst_out_data",  outDataW,      9'd0);
    checkOutput("rst_ready",     9'(aReady | bReady), 9'd0);
    checkOutput("rst_busy",      9'(busyW),     9'd0);
    checkOutput("rst_sel",       9'(selW),      9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single source A from IDLE, then a held word under backpressure.
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);

    // Both sources requesting continuously: the grant alternates in bursts.
    repeat (24) applyStimulus(1'b1, 1'b1, 1'b1);

    // B alone streams without switching.
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b1);

    // Random traffic with drops, ties and backpressure.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset in the middle of a burst, away from any clock edge.
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 9'(outValidW), 9'd0);
    checkOutput("async_ready",     9'(aReady | bReady), 9'd0);
    checkOutput("async_busy",      9'(busyW),     9'd0);
    checkOutput("async_sel",       9'(selW),      9'd0);
    checkOutput("async_out_data",  outDataW,      9'd0);
    aValid = 1'b0;
    bValid = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
